// File: rtl/image_readback_controller.sv
// image_readback_controller
//   Dumps the RGB565 image buffer over UART when the host sends CMD_DUMP.
//   Stream: SYNC_BYTE, width, height, then every buffer byte in address order.
//   Optional build macro READBACK_CHECKSUM_EN appends one XOR byte over the payload.
//
//   Handshakes:
//     rx_ready  : 1-cycle pulse, rx_data valid on that cycle.
//     mem_req   : held high with mem_addr stable until the 1-cycle mem_ready pulse,
//                 which carries mem_out; only one read is ever outstanding.
//     tx_ready  : 1-cycle pulse, issued only while tx_busy is low; tx_data stays
//                 stable from the pulse until the next byte is loaded.
//   state_dbg exposes the FSM state for checkers.
module image_readback_controller #(
  parameter int          IMAGE_BUF_X = 40,
  parameter int          IMAGE_BUF_Y = 30,
  parameter logic [7:0]  CMD_DUMP    = 8'h44,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        tx_busy,
  input  logic        mem_ready,
  input  logic [7:0]  mem_out,
  output logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        busy,
  output logic        dump_ended,
  output logic [3:0]  state_dbg
);

  localparam int N  = IMAGE_BUF_X * IMAGE_BUF_Y * 2;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_SEND,
    S_GUARD,
    S_WAIT,
    S_MEM_REQ,
    S_MEM_WAIT,
`ifdef READBACK_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  // Which part of the stream the byte in flight belongs to.
  typedef enum logic [1:0] {
    PH_HDR,
    PH_DATA,
    PH_CSUM
  } phase_t;

  state_t          state;
  phase_t          phase;
  logic [1:0]      hdr_idx;
  logic [AW-1:0]   idx;
`ifdef READBACK_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign state_dbg = state;

  // Main sequencer: header, then fetch/send each buffer byte, then finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= PH_HDR;
      hdr_idx    <= 2'd0;
      idx        <= '0;
      tx_data    <= 8'h00;
      tx_ready   <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      busy       <= 1'b0;
      dump_ended <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      tx_ready   <= 1'b0;
      dump_ended <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_ready && (rx_data == CMD_DUMP)) begin
            busy    <= 1'b1;
            idx     <= '0;
            hdr_idx <= 2'd0;
            phase   <= PH_HDR;
`ifdef READBACK_CHECKSUM_EN
            csum    <= 8'h00;
`endif
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          case (hdr_idx)
            2'd0:    tx_data <= SYNC_BYTE;
            2'd1:    tx_data <= 8'(IMAGE_BUF_X);
            default: tx_data <= 8'(IMAGE_BUF_Y);
          endcase
          state <= S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_ready <= 1'b1;
            state    <= S_GUARD;
          end
        end
        // uart_tx raises tx_busy a cycle after the pulse; do not look at it yet.
        S_GUARD: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_busy) begin
            case (phase)
              PH_HDR: begin
                if (hdr_idx == 2'd2) begin
                  phase <= PH_DATA;
                  state <= S_MEM_REQ;
                end else begin
                  hdr_idx <= hdr_idx + 2'd1;
                  state   <= S_HDR;
                end
              end
              PH_DATA: begin
                if (idx == LAST_IDX) begin
`ifdef READBACK_CHECKSUM_EN
                  phase <= PH_CSUM;
                  state <= S_CSUM;
`else
                  state <= S_DONE;
`endif
                end else begin
                  idx   <= idx + AW'(1);
                  state <= S_MEM_REQ;
                end
              end
              default: state <= S_DONE;
            endcase
          end
        end
        S_MEM_REQ: begin
          mem_addr <= 32'(idx);
          mem_req  <= 1'b1;
          state    <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            tx_data <= mem_out;
            mem_req <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
            csum    <= csum ^ mem_out;
`endif
            state   <= S_SEND;
          end
        end
`ifdef READBACK_CHECKSUM_EN
        S_CSUM: begin
          tx_data <= csum;
          state   <= S_SEND;
        end
`endif
        S_DONE: begin
          dump_ended <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_readback_controller.sv
// Directed bench for image_readback_controller with a 2x2 buffer (8 bytes).
// A UART model holds tx_busy for tx_len cycles per byte; a RAM model answers
// each read after mem_lat cycles with RAM[a] = a + 1.
module tb_image_readback_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        tx_busy = 1'b0;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_out = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        busy;
  logic        dump_ended;
  logic [3:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rec_q[$];
  logic [31:0] addr_q[$];
  int dump_cnt = 0;
  int proto_err = 0;
  int tx_len = 1;
  int mem_lat = 0;
  int tx_cnt = 0;
  int mcnt = 0;
  bit pend = 0;

  image_readback_controller #(
    .IMAGE_BUF_X(2),
    .IMAGE_BUF_Y(2),
    .CMD_DUMP(8'h44),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .mem_ready(mem_ready), .mem_out(mem_out),
    .tx_data(tx_data), .tx_ready(tx_ready), .mem_req(mem_req),
    .mem_addr(mem_addr), .busy(busy), .dump_ended(dump_ended),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // UART transmitter model and output logger
  always @(negedge clk) begin
    if (dump_ended) dump_cnt++;
    if (tx_ready) begin
      if (tx_busy) proto_err++;
      rec_q.push_back(tx_data);
      tx_cnt = tx_len;
      tx_busy = 1'b1;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_busy = 1'b0;
    end
  end

  // RAM model: one read at a time, answered after mem_lat cycles
  always @(negedge clk) begin
    if (reset) begin
      pend = 0;
      mem_ready = 1'b0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (pend) begin
      if (!mem_req) proto_err++;
      if (mcnt == 0) begin
        mem_ready = 1'b1;
        mem_out = 8'(mem_addr + 32'd1);
        pend = 0;
      end else begin
        mcnt--;
      end
    end else if (mem_req) begin
      pend = 1;
      mcnt = mem_lat;
      addr_q.push_back(mem_addr);
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_logs();
    rec_q.delete();
    addr_q.delete();
    dump_cnt = 0;
  endtask

  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
`ifdef READBACK_CHECKSUM_EN
    exp_q.push_back(8'h08);
`endif
  endtask

  task automatic wait_dump(input string name, input int budget);
    int start;
    int n;
    start = dump_cnt;
    n = 0;
    while (dump_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dump_cnt == start) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no dump_ended within %0d cycles", name, budget);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_bytes(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (rec_q.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rec_q.size() < cnt) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got %0d bytes, need %0d", name, rec_q.size(), cnt);
    end
  endtask

  task automatic check_stream(input string name);
    int m;
    checks++;
    if (rec_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_len: got %0d bytes, expected %0d", name, rec_q.size(), exp_q.size());
    end
    m = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (rec_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_byte%0d: got %02h, expected %02h", name, i, rec_q[i], exp_q[i]);
      end
    end
    checks++;
    if (addr_q.size() !== 8) begin
      failures++;
      $display("FAIL %s_nreads: got %0d reads, expected 8", name, addr_q.size());
    end
    for (int i = 0; i < addr_q.size() && i < 8; i++) begin
      checks++;
      if (addr_q[i] !== 32'(i)) begin
        failures++;
        $display("FAIL %s_addr%0d: got %0h, expected %0h", name, i, addr_q[i], i);
      end
    end
    checks++;
    if (dump_cnt !== 1) begin
      failures++;
      $display("FAIL %s_dump_ended: got %0d pulses, expected 1", name, dump_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_after: got %b, expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, mem_req, busy, dump_ended} !== 4'b0000 || tx_data !== 8'h00 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got tx_ready=%b mem_req=%b busy=%b dump_ended=%b tx_data=%02h mem_addr=%0h, expected all 0",
               tx_ready, mem_req, busy, dump_ended, tx_data, mem_addr);
    end
    reset = 1'b0;
    // Start a dump, then hit reset mid-cycle while a read is outstanding.
    tx_len = 1;
    mem_lat = 7;
    send_cmd(8'h44);
    n = 0;
    while (!mem_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre: got mem_req=%b busy=%b, expected 1 1", mem_req, busy);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || tx_data !== 8'h00 || tx_ready !== 1'b0 || dump_ended !== 1'b0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: got busy=%b mem_req=%b tx_data=%02h tx_ready=%b dump_ended=%b, expected all 0",
               busy, mem_req, tx_data, tx_ready, dump_ended);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    repeat (30) @(negedge clk);
    checks++;
    if (dump_cnt !== 0 || rec_q.size() !== 0) begin
      failures++;
      $display("FAIL reset_abort: got dump_ended=%0d bytes=%0d, expected 0 0", dump_cnt, rec_q.size());
    end
  endtask

  task automatic test_dump();
    int n;
    tx_len = 1;
    mem_lat = 0;
    clear_logs();
    @(negedge clk);
    rx_data = 8'h44;
    rx_ready = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (n == 0) rx_ready = 1'b0;
      n++;
      if (tx_ready) break;
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL dump_latency: first tx_ready at negedge %0d after command, expected 3", n);
    end
    wait_dump("dump", 2000);
    check_stream("dump");
  endtask

  task automatic test_ignore();
    clear_logs();
    send_cmd(8'h41);
    repeat (20) @(negedge clk);
    checks++;
    if (rec_q.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_other: got bytes=%0d busy=%b, expected 0 0", rec_q.size(), busy);
    end
    tx_len = 2;
    mem_lat = 1;
    send_cmd(8'h44);
    wait_bytes("ignore", 5, 500);
    send_cmd(8'h44);
    wait_dump("ignore", 2000);
    check_stream("ignore");
  endtask

  task automatic test_slow();
    clear_logs();
    tx_len = 50;
    mem_lat = 7;
    send_cmd(8'h44);
    wait_dump("slow", 5000);
    check_stream("slow");
  endtask

  task automatic test_reset_mid();
    clear_logs();
    tx_len = 3;
    mem_lat = 2;
    send_cmd(8'h44);
    wait_bytes("midrst", 4, 500);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    clear_logs();
    repeat (20) @(negedge clk);
    checks++;
    if (dump_cnt !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort: got dump_ended=%0d busy=%b, expected 0 0", dump_cnt, busy);
    end
    send_cmd(8'h44);
    wait_dump("midrst", 2000);
    check_stream("midrst");
  endtask

  initial begin
    build_exp();
    test_reset();
    test_dump();
    test_ignore();
    test_slow();
    test_reset_mid();
    checks++;
    if (proto_err !== 0) begin
      failures++;
      $display("FAIL protocol: got %0d handshake violations, expected 0", proto_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
